kbd_scan_decoder: RTL
=====================

KBD_SCAN_DECODER -- requirements
Module: kbd_scan_decoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, meaning output queue depth in entries (power of two, 2..16).
REQ-002 Parameter REPEAT_EN, default 1, meaning 1 enables internal autorepeat, 0 passes keyboard typematic makes through.
REQ-003 Parameter REPEAT_DELAY, default 25000000, meaning clk cycles from a make code to the first repeat.
REQ-004 Parameter REPEAT_RATE, default 2500000, meaning clk cycles between subsequent repeats.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high; clears all state.
REQ-007 scan_valid  in  1  one-cycle strobe; scan_code is valid this cycle.
REQ-008 scan_code  in  8  raw PS/2 set-2 byte.
REQ-009 key_ready  in  1  consumer accepts the head entry when key_valid=1.
REQ-010 key_valid  out  1  queue non-empty.
REQ-011 key_code  out  7  BK key code at queue head.
REQ-012 key_ar2  out  1  AR2 flag at queue head (sent with AR2 held).
REQ-013 key_held  out  1  a translatable key is currently held.
REQ-014 shift_state  out  1  left shift currently held.
REQ-015 overflow  out  1  sticky; an entry was dropped on a full queue.

Function
REQ-016 The prefix FSM SHALL have states IDLE, EXT (after 0xE0), BRK (after 0xF0) and EXT_BRK (after 0xE0,0xF0); bytes are consumed only on scan_valid.
REQ-017 Transitions SHALL be: IDLE -0xE0-> EXT; IDLE -0xF0-> BRK; EXT -0xF0-> EXT_BRK; any other byte completes a make (IDLE/EXT) or break (BRK/EXT_BRK) and returns to IDLE.
REQ-018 Bytes 0xAA, 0xFA, 0xFE, 0xEE and 0x00 in IDLE SHALL be ignored without state change.
REQ-019 Make/break 0x12 SHALL set/clear shift_state; 0x14 (with or without E0) SHALL set/clear an internal ctrl flag; E0 0x12 and E0 0x7C SHALL be ignored.
REQ-020 A make SHALL be translated by a combinational lookup of {shift_state, ext, scan_code} to {code[6:0], ar2} per the BK-0010 keymap; code 0 means unmapped and produces nothing.
REQ-021 With ctrl=1, lookup results 0x40..0x7F SHALL be emitted as code & 0x1F with ar2=0.
REQ-022 A mapped make SHALL enqueue one entry; the entry SHALL be visible on key_valid/key_code the cycle after the scan_valid carrying the final byte (latency 1).
REQ-023 Break codes SHALL never enqueue entries.
REQ-024 A mapped make SHALL latch held key {ext, scan_code, code, ar2}, set key_held=1 and load the repeat counter with REPEAT_DELAY.
REQ-025 A break matching the held {ext, scan_code} SHALL clear key_held and stop repeat; non-matching breaks SHALL not affect it.
REQ-026 A make of a different key SHALL replace the held key and restart REPEAT_DELAY.
REQ-027 REPEAT_EN=1: a make equal to the held key SHALL be ignored; counter expiry SHALL enqueue the held entry and reload with REPEAT_RATE.
REQ-028 REPEAT_EN=0: no internal repeats; every mapped make enqueues.
REQ-029 Queue SHALL be FIFO, first-word-fall-through; dequeue when key_valid & key_ready.
REQ-030 If an enqueue and dequeue coincide on a full queue, both SHALL occur and no drop SHALL be flagged.
REQ-031 An enqueue on a full queue without dequeue SHALL drop the new entry and set overflow, which stays 1 until reset.
REQ-032 Make-enqueue and repeat-enqueue in the same cycle SHALL resolve to the make only; repeat counter restarts.
REQ-033 Counters and pointers SHALL wrap modulo their widths without glitching key_valid.

Reset
REQ-034 While reset=1: FSM=IDLE, queue empty, key_valid=0, key_code=0, key_ar2=0, key_held=0, shift_state=0, ctrl=0, overflow=0, repeat counter=0.
REQ-035 Reset asserted mid-prefix or mid-repeat SHALL discard the partial sequence and held key; first byte after release is decoded from IDLE.

Verification
REQ-036 0x1C -> key_code=0x61, ar2=0 next cycle; 0x12,0x1C -> 0x41; 0xF0,0x1C adds nothing.
REQ-037 0x05 -> key_code=0x01, key_ar2=1; 0xE0,0x75 -> 0x1A; 0xE0,0xF0,0x75 -> no entry; 0x14,0x21 -> 0x03.
REQ-038 REPEAT_DELAY=10, REPEAT_RATE=4, key_ready=1: make 0x1C, hold 30 cycles -> entries at +1, +11, +15, +19, +23, +27; break stops further entries.
REQ-039 FIFO_DEPTH=4, key_ready=0, 6 mapped makes -> 4 entries in order, overflow=1; then key_ready=1 drains 4 and key_valid=0.
REQ-040 Full queue, key_ready=1 and make in same cycle -> count stays 4, overflow stays 0.
REQ-041 0xE0 then reset pulse then 0x75 -> key_code=0x7F-free check: entry is unextended lookup of 0x75, FSM not EXT.

Source files
------------

// File: rtl/kbd_scan_decoder.sv
// kbd_scan_decoder: PS/2 set-2 scan bytes to BK-0010 key codes.
// Prefix FSM, keymap, held-key autorepeat and a FWFT output queue.
// Ports: clk, reset (async, high); scan_valid/scan_code byte in;
// key_valid/key_ready/key_code/key_ar2 queue head handshake;
// key_held, shift_state, overflow (sticky drop) status.
module kbd_scan_decoder #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int          REPEAT_EN    = 1,
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_RATE  = 2500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  input  logic       key_ready,
  output logic       key_valid,
  output logic [6:0] key_code,
  output logic       key_ar2,
  output logic       key_held,
  output logic       shift_state,
  output logic       overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned RMAX =
    (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CW = $clog2(RMAX + 1);
  localparam bit REP = (REPEAT_EN != 0);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } state_t;

  state_t state, state_nx;

  logic          done;
  logic          cur_ext, cur_brk;
  logic          ign;
  logic          is_shift, is_ctrl, is_skip;
  logic          modifier;
  logic          make, brk;
  logic [6:0]    lk_code;
  logic          lk_ar2;
  logic [4:0]    letter;
  logic [3:0]    digit;
  logic [6:0]    tr_code;
  logic          tr_ar2;
  logic          same_key;
  logic          make_enq;
  logic          brk_match;
  logic          rep_fire;
  logic          enq;
  logic [7:0]    enq_data;

  logic          ctrl_q;
  logic          held_q;
  logic          held_ext;
  logic [7:0]    held_sc;
  logic [6:0]    held_code;
  logic          held_ar2;
  logic [CW-1:0] rep_cnt;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, deq, push;
  logic          ovf_q;
  logic [7:0]    head;

  assign ign = (scan_code == 8'hAA) || (scan_code == 8'hFA) ||
               (scan_code == 8'hFE) || (scan_code == 8'hEE) ||
               (scan_code == 8'h00);

  always_comb begin
    state_nx = state;
    done     = 1'b0;
    if (scan_valid) begin
      unique case (state)
        IDLE: begin
          if (scan_code == 8'hE0)      state_nx = EXT;
          else if (scan_code == 8'hF0) state_nx = BRK;
          else if (!ign)               done = 1'b1;
        end
        EXT: begin
          if (scan_code == 8'hF0) begin
            state_nx = EXT_BRK;
          end else begin
            state_nx = IDLE;
            done     = 1'b1;
          end
        end
        BRK, EXT_BRK: begin
          state_nx = IDLE;
          done     = 1'b1;
        end
      endcase
    end
  end

  assign cur_ext  = (state == EXT) || (state == EXT_BRK);
  assign cur_brk  = (state == BRK) || (state == EXT_BRK);
  assign make     = done && !cur_brk;
  assign brk      = done && cur_brk;
  assign is_shift = !cur_ext && (scan_code == 8'h12);
  assign is_ctrl  = (scan_code == 8'h14);
  assign is_skip  = cur_ext &&
                    ((scan_code == 8'h12) || (scan_code == 8'h7C));
  assign modifier = is_shift || is_ctrl || is_skip;

  // Letters and digits resolve to an index first so the shift
  // variant is plain arithmetic instead of a second table.
  always_comb begin
    lk_code = 7'd0;
    lk_ar2  = 1'b0;
    letter  = 5'd31;
    digit   = 4'd15;
    if (cur_ext) begin
      case (scan_code)
        8'h75:   lk_code = 7'h1A;
        8'h72:   lk_code = 7'h1B;
        8'h6B:   lk_code = 7'h08;
        8'h74:   lk_code = 7'h19;
        8'h5A:   lk_code = 7'h0A;
        default: lk_code = 7'd0;
      endcase
    end else begin
      case (scan_code)
        8'h1C: letter = 5'd0;
        8'h32: letter = 5'd1;
        8'h21: letter = 5'd2;
        8'h23: letter = 5'd3;
        8'h24: letter = 5'd4;
        8'h2B: letter = 5'd5;
        8'h34: letter = 5'd6;
        8'h33: letter = 5'd7;
        8'h43: letter = 5'd8;
        8'h3B: letter = 5'd9;
        8'h42: letter = 5'd10;
        8'h4B: letter = 5'd11;
        8'h3A: letter = 5'd12;
        8'h31: letter = 5'd13;
        8'h44: letter = 5'd14;
        8'h4D: letter = 5'd15;
        8'h15: letter = 5'd16;
        8'h2D: letter = 5'd17;
        8'h1B: letter = 5'd18;
        8'h2C: letter = 5'd19;
        8'h3C: letter = 5'd20;
        8'h2A: letter = 5'd21;
        8'h1D: letter = 5'd22;
        8'h22: letter = 5'd23;
        8'h35: letter = 5'd24;
        8'h1A: letter = 5'd25;
        8'h45: digit = 4'd0;
        8'h16: digit = 4'd1;
        8'h1E: digit = 4'd2;
        8'h26: digit = 4'd3;
        8'h25: digit = 4'd4;
        8'h2E: digit = 4'd5;
        8'h36: digit = 4'd6;
        8'h3D: digit = 4'd7;
        8'h3E: digit = 4'd8;
        8'h46: digit = 4'd9;
        8'h29: lk_code = 7'h20;
        8'h5A: lk_code = 7'h0A;
        8'h66: lk_code = 7'h18;
        8'h0D: lk_code = 7'h09;
        8'h76: lk_code = 7'h1B;
        8'h05: begin lk_code = 7'h01; lk_ar2 = 1'b1; end
        8'h06: begin lk_code = 7'h02; lk_ar2 = 1'b1; end
        8'h04: begin lk_code = 7'h03; lk_ar2 = 1'b1; end
        8'h0C: begin lk_code = 7'h04; lk_ar2 = 1'b1; end
        8'h75: lk_code = 7'h38;
        8'h72: lk_code = 7'h32;
        8'h6B: lk_code = 7'h34;
        8'h74: lk_code = 7'h36;
        8'h73: lk_code = 7'h35;
        default: lk_code = 7'd0;
      endcase
      if (letter != 5'd31)
        lk_code = (shift_state ? 7'h41 : 7'h61) + {2'b00, letter};
      if (digit != 4'd15)
        lk_code = (shift_state && digit != 4'd0)
                ? 7'h20 + {3'b000, digit}
                : 7'h30 + {3'b000, digit};
    end
  end

  assign tr_code = (ctrl_q && lk_code[6]) ? {2'b00, lk_code[4:0]}
                                          : lk_code;
  assign tr_ar2  = (ctrl_q && lk_code[6]) ? 1'b0 : lk_ar2;

  assign same_key  = held_q && (held_ext == cur_ext) &&
                     (held_sc == scan_code);
  assign make_enq  = make && !modifier && (lk_code != 7'd0) &&
                     !(REP && same_key);
  assign brk_match = brk && same_key;
  // A break on the expiry cycle wins: the key is already up.
  assign rep_fire  = REP && held_q && (rep_cnt == CW'(1)) &&
                     !make_enq && !brk_match;
  assign enq       = make_enq || rep_fire;
  assign enq_data  = make_enq ? {tr_code, tr_ar2}
                              : {held_code, held_ar2};

  assign full = (count == FULL);
  assign deq  = key_valid && key_ready;
  // A full queue still accepts when the head leaves this cycle.
  assign push = enq && (!full || deq);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shift_state <= 1'b0;
      ctrl_q      <= 1'b0;
      held_q      <= 1'b0;
      held_ext    <= 1'b0;
      held_sc     <= 8'd0;
      held_code   <= 7'd0;
      held_ar2    <= 1'b0;
      rep_cnt     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state <= state_nx;
      if (done && is_shift) shift_state <= !cur_brk;
      if (done && is_ctrl)  ctrl_q      <= !cur_brk;
      if (make_enq) begin
        held_q    <= 1'b1;
        held_ext  <= cur_ext;
        held_sc   <= scan_code;
        held_code <= tr_code;
        held_ar2  <= tr_ar2;
        rep_cnt   <= CW'(REPEAT_DELAY);
      end else if (brk_match) begin
        held_q  <= 1'b0;
        rep_cnt <= '0;
      end else if (held_q && rep_cnt != '0) begin
        rep_cnt <= (rep_cnt == CW'(1)) ? CW'(REPEAT_RATE)
                                       : rep_cnt - 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (deq)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !deq)      count <= count + 1'b1;
      else if (!push && deq) count <= count - 1'b1;
      if (enq && full && !deq) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enq_data;
  end

  assign head      = mem[rd_ptr];
  assign key_valid = (count != '0);
  assign key_code  = key_valid ? head[7:1] : 7'd0;
  assign key_ar2   = key_valid ? head[0] : 1'b0;
  assign key_held  = held_q;
  assign overflow  = ovf_q;

endmodule
